// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture engine: sample width,
// FSM state encodings, ASCII codes and the nibble-to-hex-character helper.
package la_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DUMP = 3'd4;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase hex character for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = ASCII_0 + {4'h0, nib};
        end else begin
            c = ASCII_A + {4'h0, nib} - 8'd10;
        end
        return c;
    endfunction

endpackage

// File: rtl/la_capture_dump_if.sv
// Byte-write handshake between the capture engine and the uart_tx6 transmit FIFO.
interface la_capture_dump_if;

    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_full;

    modport master (
        output tx_data,
        output tx_write,
        input  tx_full
    );

    modport slave (
        input  tx_data,
        input  tx_write,
        output tx_full
    );

endinterface

// File: rtl/la_sample_ram.sv
// Capture buffer: one write port and one registered read port, shaped for block RAM.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int AW = 10,
    parameter int W  = SAMPLE_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [0:(1<<AW)-1];

    // Sample write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/la_capture_dump.sv
// Logic-analyzer capture engine: circular pre/post-trigger capture of the probe
// pins, then a dump of the record, oldest first, as ASCII hex lines to the UART FIFO.
module la_capture_dump
    import la_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 256
) (
    input  logic                clk,
    input  logic                btnCpuReset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_en,
    input  logic                arm,
    input  logic [SAMPLE_W-1:0] trig_mask,
    input  logic [SAMPLE_W-1:0] trig_value,
    la_capture_dump_if.master   tx,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
    localparam logic [AW-1:0] SMP_LAST  = AW'(DEPTH - 1);
    localparam bit            NO_POST   = (PRE_TRIG == DEPTH - 1);

    logic [2:0]          state_r;
    logic [AW-1:0]       wp_r;
    logic [AW-1:0]       cnt_r;
    logic [AW-1:0]       trig_addr_r;
    logic [AW-1:0]       rd_addr_r;
    logic [AW-1:0]       smp_cnt_r;
    logic [2:0]          nib_r;
    logic                prime_r;
    logic                last_r;
    logic                valid_r;
    logic                done_r;
    logic                triggered_r;
    logic [7:0]          byte_r;

    logic                we_s;
    logic                match_s;
    logic                take_s;
    logic                load_s;
    logic [7:0]          next_byte_s;
    logic [SAMPLE_W-1:0] rdata_s;

    la_sample_ram #(
        .AW (AW),
        .W  (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wp_r),
        .wdata (sample_in),
        .raddr (rd_addr_r),
        .rdata (rdata_s)
    );

    // Write enable, trigger match and dump byte-pipeline control.
    always_comb begin
        we_s    = 1'b0;
        load_s  = 1'b0;
        match_s = ((sample_in & trig_mask) == (trig_value & trig_mask));
        take_s  = valid_r & ~tx.tx_full;
        if (sample_en && ((state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST))) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
        // A new byte enters the output register whenever it is empty or being drained.
        if ((state_r == ST_DUMP) && !prime_r && !last_r && (!valid_r || take_s)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Byte for the current line position: four hex digits, MSB first, then LF.
    always_comb begin
        next_byte_s = ASCII_LF;
        case (nib_r)
            3'd0:    next_byte_s = hex_ascii(rdata_s[15:12]);
            3'd1:    next_byte_s = hex_ascii(rdata_s[11:8]);
            3'd2:    next_byte_s = hex_ascii(rdata_s[7:4]);
            3'd3:    next_byte_s = hex_ascii(rdata_s[3:0]);
            default: next_byte_s = ASCII_LF;
        endcase
    end

    // Capture FSM, write pointer and dump sequencer.
    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            state_r     <= ST_IDLE;
            wp_r        <= '0;
            cnt_r       <= '0;
            trig_addr_r <= '0;
            rd_addr_r   <= '0;
            smp_cnt_r   <= '0;
            nib_r       <= 3'd0;
            prime_r     <= 1'b1;
            last_r      <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            triggered_r <= 1'b0;
            byte_r      <= 8'h00;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wp_r        <= '0;
                    cnt_r       <= '0;
                    smp_cnt_r   <= '0;
                    nib_r       <= 3'd0;
                    prime_r     <= 1'b1;
                    last_r      <= 1'b0;
                    valid_r     <= 1'b0;
                    triggered_r <= 1'b0;
                    if (arm) begin
                        state_r <= (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (sample_en) begin
                        wp_r <= wp_r + ONE;
                        if (wp_r == PRE_LAST) begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sample_en) begin
                        wp_r <= wp_r + ONE;
                        if (match_s) begin
                            trig_addr_r <= wp_r;
                            triggered_r <= 1'b1;
                            cnt_r       <= '0;
                            if (NO_POST) begin
                                state_r   <= ST_DUMP;
                                rd_addr_r <= wp_r - PRE_OFF;
                            end else begin
                                state_r <= ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        wp_r  <= wp_r + ONE;
                        cnt_r <= cnt_r + ONE;
                        if (cnt_r == POST_LAST) begin
                            state_r   <= ST_DUMP;
                            rd_addr_r <= trig_addr_r - PRE_OFF;
                        end
                    end
                end
                ST_DUMP: begin
                    // First dump cycle only waits for the RAM to return the oldest sample.
                    prime_r <= 1'b0;
                    if (load_s) begin
                        byte_r  <= next_byte_s;
                        valid_r <= 1'b1;
                        if (nib_r == 3'd4) begin
                            nib_r <= 3'd0;
                            if (smp_cnt_r == SMP_LAST) begin
                                last_r <= 1'b1;
                            end else begin
                                smp_cnt_r <= smp_cnt_r + ONE;
                            end
                        end else begin
                            nib_r <= nib_r + 3'd1;
                            // Last digit taken: fetch the next sample while LF goes out.
                            if (nib_r == 3'd3) begin
                                rd_addr_r <= rd_addr_r + ONE;
                            end
                        end
                    end else if (take_s) begin
                        valid_r <= 1'b0;
                        if (last_r) begin
                            state_r     <= ST_IDLE;
                            done_r      <= 1'b1;
                            triggered_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = byte_r;
    assign tx.tx_write = take_s;
    assign busy        = (state_r != ST_IDLE);
    assign triggered   = triggered_r;
    assign done        = done_r;

endmodule

// File: tb/tb_la_capture_dump.sv
// Scenario bench for la_capture_dump: ramp probe input, scoreboard of expected
// ASCII dump bytes popped on every tx_write.
module tb_la_capture_dump;
    import la_pkg::*;

    localparam int DL    = 4;
    localparam int PT    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        btnCpuReset;
    logic [15:0] sample_in;
    logic        sample_en;
    logic        arm;
    logic [15:0] trig_mask;
    logic [15:0] trig_value;
    logic        busy;
    logic        triggered;
    logic        done;

    la_capture_dump_if tx_if ();

    la_capture_dump #(
        .DEPTH_LOG2 (DL),
        .PRE_TRIG   (PT)
    ) dut (
        .clk         (clk),
        .btnCpuReset (btnCpuReset),
        .sample_in   (sample_in),
        .sample_en   (sample_en),
        .arm         (arm),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .tx          (tx_if.master),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          n_bytes = 0;
    int          exp_trig = 0;
    bit          lat_chk = 1'b0;
    bit          first_wr = 1'b0;
    bit          full_rand = 1'b0;
    string       hexd = "0123456789ABCDEF";

    // One clock: inputs change 1 time unit after the edge; the probe ramp advances.
    task automatic tick();
        @(posedge clk);
        #1;
        sample_in = sample_in + 16'd1;
        if (full_rand) tx_if.tx_full = 1'($urandom_range(0, 1));
    endtask

    function automatic int find_trig(logic [15:0] m, logic [15:0] v);
        for (int k = PT; k < 4096; k++) begin
            if ((16'(k) & m) == (v & m)) return k;
        end
        return -1;
    endfunction

    task automatic push_expected(int t);
        logic [15:0] w;
        for (int s = t - PT; s < t - PT + DEPTH; s++) begin
            w = 16'(s);
            for (int n = 3; n >= 0; n--) exp_q.push_back(hexd[w[n*4 +: 4]]);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Byte scoreboard, full-handshake guard and trigger-timing monitor.
    initial begin
        logic [7:0] e;
        bit         trig_prev;
        trig_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_if.tx_write === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %02h, no byte expected", tx_if.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_if.tx_data !== e) begin
                        errors++;
                        $display("FAIL dump_byte[%0d]: got %02h, expected %02h", n_bytes, tx_if.tx_data, e);
                    end
                end
                if (first_wr && lat_chk) begin
                    checks++;
                    if (sample_in > 16'(exp_trig + 15)) begin
                        errors++;
                        $display("FAIL first_write_latency: ramp at %0d, expected <= %0d", sample_in, exp_trig + 15);
                    end
                end
                first_wr = 1'b0;
                n_bytes++;
            end
            if (tx_if.tx_full === 1'b1) begin
                checks++;
                if (tx_if.tx_write !== 1'b0) begin
                    errors++;
                    $display("FAIL write_while_full: tx_write=%b, expected 0", tx_if.tx_write);
                end
            end
            if (triggered === 1'b1 && !trig_prev) begin
                checks++;
                if (sample_in !== 16'(exp_trig + 1)) begin
                    errors++;
                    $display("FAIL trigger_timing: rose with ramp %0d, expected %0d", sample_in, exp_trig + 1);
                end
            end
            trig_prev = (triggered === 1'b1);
        end
    end

    task automatic apply_reset(string where);
        btnCpuReset = 1'b0;
        tick();
        checks++;
        if (tx_if.tx_write !== 1'b0 || tx_if.tx_data !== 8'h00 || busy !== 1'b0 ||
            triggered !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s: write=%b data=%02h busy=%b trig=%b done=%b, expected all 0",
                     where, tx_if.tx_write, tx_if.tx_data, busy, triggered, done);
        end
        btnCpuReset = 1'b1;
        exp_q.delete();
    endtask

    task automatic start_capture(logic [15:0] m, logic [15:0] v, bit rnd);
        trig_mask  = m;
        trig_value = v;
        exp_trig   = find_trig(m, v);
        exp_q.delete();
        push_expected(exp_trig);
        n_bytes    = 0;
        first_wr   = 1'b1;
        lat_chk    = !rnd;
        arm        = 1'b1;
        sample_in  = 16'hFFFF;
        tick();
        arm = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_arm: got %b, expected 1", busy);
        end
    endtask

    task automatic wait_done(string name);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, expected 1", name, done, cyc);
        end else begin
            checks++;
            if (n_bytes != 80 || exp_q.size() != 0 || triggered !== 1'b0) begin
                errors++;
                $display("FAIL %s_byte_count: wrote %0d, left %0d, trig=%b, expected 80, 0, 0",
                         name, n_bytes, exp_q.size(), triggered);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        apply_reset("initial");
    endtask

    task automatic test_exact_trigger();
        start_capture(16'hFFFF, 16'h000A, 1'b0);
        wait_done("exact");
    endtask

    task automatic test_mask_zero();
        start_capture(16'h0000, 16'h1234, 1'b0);
        wait_done("mask0");
    endtask

    task automatic test_wrap();
        start_capture(16'h00FF, 16'h0013, 1'b0);
        wait_done("wrap");
    endtask

    task automatic test_backpressure();
        full_rand = 1'b1;
        start_capture(16'hFFFF, 16'h000A, 1'b1);
        wait_done("stall");
        full_rand = 1'b0;
        tx_if.tx_full = 1'b0;
    endtask

    task automatic test_reset_abort();
        int cyc;
        start_capture(16'hFFFF, 16'h000A, 1'b0);
        cyc = 0;
        while (triggered !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        repeat (3) tick();
        apply_reset("post");
        start_capture(16'hFFFF, 16'h000A, 1'b0);
        cyc = 0;
        while (n_bytes < 12 && cyc < 400) begin tick(); cyc++; end
        checks++;
        if (n_bytes < 12) begin
            errors++;
            $display("FAIL abort_dump_start: wrote %0d bytes, expected >= 12", n_bytes);
        end
        apply_reset("dump");
        start_capture(16'hFFFF, 16'h000A, 1'b0);
        wait_done("rearm");
    endtask

    task automatic test_arm_ignored();
        int cyc;
        start_capture(16'hFFFF, 16'h000A, 1'b0);
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cyc = 0;
        while (n_bytes < 3 && cyc < 400) begin tick(); cyc++; end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_done("arm_ign");
        repeat (40) tick();
        checks++;
        if (busy !== 1'b0 || n_bytes != 80) begin
            errors++;
            $display("FAIL arm_ignored: busy=%b bytes=%0d, expected 0 and 80", busy, n_bytes);
        end
    endtask

    initial begin
        btnCpuReset   = 1'b0;
        sample_in     = 16'h0000;
        sample_en     = 1'b1;
        arm           = 1'b0;
        trig_mask     = 16'h0000;
        trig_value    = 16'h0000;
        tx_if.tx_full = 1'b0;
        test_reset();
        test_exact_trigger();
        test_mask_zero();
        test_wrap();
        test_backpressure();
        test_reset_abort();
        test_arm_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/la_capture_dump.md
# la_capture_dump

Logic-analyzer capture engine feeding the UART transmit path.
- Samples the 16 probe pins ({JB, JA}) into an on-chip circular buffer.
- Holds a programmable pre-trigger window and waits for a masked pattern trigger.
- Fills the post-trigger window, then streams the whole record, oldest first, as ASCII hex lines into the `uart_tx6` transmit FIFO.
- Sits between the nexys4fpga pin inputs and `uart_tx6`; only the FIFO write handshake faces the UART.

## Interface
- `DEPTH_LOG2`, 10, log2 of buffer depth in samples (DEPTH = 2^DEPTH_LOG2).
- `PRE_TRIG`, 256, samples kept before the trigger sample; legal range 0..DEPTH-1.
- `clk`  in  1  system clock (100 MHz); only clock.
- `btnCpuReset`  in  1  reset; synchronous, active-low.
- `sample_in`  in  16  probe word {JB, JA}; pre-synchronised upstream.
- `sample_en`  in  1  sample strobe; one sample per cycle with it high.
- `arm`  in  1  start capture; single-cycle pulse, honoured only in IDLE.
- `trig_mask`  in  16  trigger bit mask; 1 = compared.
- `trig_value`  in  16  trigger pattern.
- `tx_data`  out  8  byte to `uart_tx6.data_in`.
- `tx_write`  out  1  to `uart_tx6.buffer_write`.
- `tx_full`  in  1  from `uart_tx6.buffer_full`.
- `busy`  out  1  high in any state except IDLE.
- `triggered`  out  1  high from the trigger sample until return to IDLE.
- `done`  out  1  one-cycle pulse after the last dump byte is written.

## Operation
- States: IDLE, PRE, WAIT, POST, DUMP.
- IDLE:
  - write pointer `wp` = 0.
  - `arm` -> PRE; if PRE_TRIG = 0, go straight to WAIT.
- PRE: each `sample_en` writes `sample_in` at `wp`, `wp` += 1. After PRE_TRIG writes -> WAIT.
- WAIT:
  - each `sample_en` writes at `wp` and increments `wp` modulo DEPTH (wraps).
  - If `(sample_in & trig_mask) == (trig_value & trig_mask)`, that sample is the trigger:
    - written at `wp`; `trig_addr` = `wp`.
    - `triggered` set; -> POST.
  - `trig_mask` = 0 triggers on the first WAIT sample.
- POST: continue writes until DEPTH-PRE_TRIG-1 further samples are stored -> DUMP.
- DUMP:
  - read start = (`trig_addr` - PRE_TRIG) mod DEPTH; DEPTH samples, address wraps.
  - Per sample, 5 bytes:
    - four ASCII hex nibbles, MSB first; uppercase '0'-'9','A'-'F' (0x30-0x39, 0x41-0x46).
    - then LF (0x0A).
  - After last byte -> `done` pulse, IDLE.
- `sample_en` is ignored in DUMP and IDLE.
- `arm` outside IDLE is ignored.
- Trigger in the same cycle `wp` wraps is legal; `trig_addr` is the wrapped value.
- Trigger test applies only in WAIT with `sample_en` high; PRE samples never trigger.

## Timing
- Reset (`btnCpuReset` = 0 at a clk edge), effective next cycle:
  - state IDLE, `wp` = 0.
  - `tx_data` = 0x00, `tx_write` = 0, `busy` = 0, `triggered` = 0, `done` = 0.
- Reset mid-capture or mid-dump aborts immediately. No partial line is completed; the bytes already in the UART FIFO are its own concern.
- `arm` -> `busy` high the next cycle.
- Sample write: `sample_in` captured into RAM at the edge where `sample_en` is high.
- Trigger: `triggered` rises the cycle after the trigger sample edge.
- Buffer RAM: one synchronous read port, read latency 1 cycle.
- TX handshake:
  - `tx_write` is a one-cycle pulse, asserted only in a cycle where `tx_full` = 0; `tx_data` is valid that cycle.
  - `tx_full` high stalls the dump with no byte lost or repeated.
  - Max rate: one byte per cycle while `tx_full` = 0.
- First `tx_write` no later than 3 cycles after entering DUMP with `tx_full` low.
- `done` is asserted the cycle after the final LF write; IDLE is reached the same cycle.

## Structure
- Package `la_pkg`: state enum, ASCII constants (LF, '0', 'A'), SAMPLE_W = 16.
- Sub-module `la_sample_ram`: DEPTH x 16, one write port and one registered read port; infers BRAM.
- Hex-nibble-to-ASCII conversion is a package function, not a module.

## Test plan
Bench parameters: DEPTH_LOG2 = 4, PRE_TRIG = 4; counter ramp on `sample_in` starting 0x0000; `sample_en` = 1; `tx_full` = 0 unless stated.
1. Mask 0xFFFF, value 0x000A, arm -> trigger at sample 0x000A, `triggered` next cycle. Dump is 80 bytes: "0006\n" ... "0015\n", then `done`.
2. Mask 0x0000, arm -> trigger on first WAIT sample (0x0004). Dump lines 0x0000..0x000F.
3. Mask 0x00FF, value 0x0013 -> trigger after `wp` wrap. Dump starts "000F\n", ends "001E\n"; address wraparound correct.
4. `tx_full` toggled pseudo-randomly during dump -> byte stream identical to scenario 1. `tx_write` never high while `tx_full` = 1.
5. Reset pulse in POST and again in DUMP -> all outputs reach reset values next cycle. A new `arm` then produces a correct full capture.
6. `arm` pulses during PRE and DUMP -> ignored; single 80-byte dump.
